// File: rtl/reg_file.sv
// MIPS general-purpose register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, optional write-to-read bypass and a debug read port.
module reg_file #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                BYPASS  = 1,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_3FFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              write_ok;

  assign write_ok = we && (wa != '0) && !reset;

  // Reset wins over a same-cycle write; $0 is never written so it stays 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == 28)
          regs[i[ADDR_W-1:0]] <= GP_INIT;
        else if (i == 29)
          regs[i[ADDR_W-1:0]] <= SP_INIT;
        else
          regs[i[ADDR_W-1:0]] <= '0;
      end
    end else if (write_ok) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != '0) rd1 = regs[ra1];
    if ((BYPASS != 0) && write_ok && (wa == ra1)) rd1 = wd;
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) rd2 = regs[ra2];
    if ((BYPASS != 0) && write_ok && (wa == ra2)) rd2 = wd;
  end

  // The debug port shows stored contents only, never the in-flight write.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) dbg_data = regs[dbg_addr];
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed and random checks of reg_file; a BYPASS=1 and a BYPASS=0 instance
// share all inputs so both bypass behaviours are observed side by side.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, dbg_addr = '0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd1, rd2, dbg_data;
  logic [31:0] rd1_nb, rd2_nb, dbg_data_nb;

  int checks = 0;
  int fails  = 0;

  reg_file #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  reg_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge; checks run 1 ns later, well before the rising edge.
  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; we = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] exp;
    pulse_reset(1);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0]; ra1 = a[4:0]; ra2 = a[4:0];
      exp = (a == 28) ? 32'h0000_1800 : (a == 29) ? 32'h0000_3FFC : 32'h0;
      #1;
      checks += 3;
      if (dbg_data !== exp) begin
        fails++; $display("[TB] FAIL reset_dbg[%0d]: got %h expected %h", a, dbg_data, exp);
      end
      if (rd1 !== exp || rd2 !== exp) begin
        fails++; $display("[TB] FAIL reset_rd[%0d]: got %h/%h expected %h", a, rd1, rd2, exp);
      end
      if (dbg_data_nb !== exp) begin
        fails++; $display("[TB] FAIL reset_dbg_nb[%0d]: got %h expected %h", a, dbg_data_nb, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_read;
    we = 1'b1; wa = 5'd8; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    we = 1'b0; ra1 = 5'd8; ra2 = 5'd9; dbg_addr = 5'd8;
    #1;
    checks += 4;
    if (rd1 !== 32'hDEAD_BEEF) begin
      fails++; $display("[TB] FAIL write_rd1: got %h expected %h", rd1, 32'hDEAD_BEEF);
    end
    if (rd2 !== 32'h0) begin
      fails++; $display("[TB] FAIL write_rd2: got %h expected %h", rd2, 32'h0);
    end
    if (dbg_data !== 32'hDEAD_BEEF) begin
      fails++; $display("[TB] FAIL write_dbg: got %h expected %h", dbg_data, 32'hDEAD_BEEF);
    end
    if (rd1_nb !== 32'hDEAD_BEEF) begin
      fails++; $display("[TB] FAIL write_rd1_nb: got %h expected %h", rd1_nb, 32'hDEAD_BEEF);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_reg;
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; dbg_addr = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      fails++; $display("[TB] FAIL zero_bypass: got %h expected %h", rd1, 32'h0);
    end
    @(negedge clk);
    we = 1'b0;
    #1;
    checks += 2;
    if (rd1 !== 32'h0) begin
      fails++; $display("[TB] FAIL zero_rd1: got %h expected %h", rd1, 32'h0);
    end
    if (dbg_data !== 32'h0) begin
      fails++; $display("[TB] FAIL zero_dbg: got %h expected %h", dbg_data, 32'h0);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass;
    we = 1'b1; wa = 5'd5; wd = 32'h1234_5678; ra1 = 5'd5; ra2 = 5'd5; dbg_addr = 5'd5;
    #1;
    checks += 4;
    if (rd1 !== 32'h1234_5678 || rd2 !== 32'h1234_5678) begin
      fails++; $display("[TB] FAIL bypass_rd: got %h/%h expected %h", rd1, rd2, 32'h1234_5678);
    end
    if (dbg_data !== 32'h0) begin
      fails++; $display("[TB] FAIL bypass_dbg_old: got %h expected %h", dbg_data, 32'h0);
    end
    if (rd1_nb !== 32'h0 || rd2_nb !== 32'h0) begin
      fails++; $display("[TB] FAIL nobypass_old: got %h/%h expected %h", rd1_nb, rd2_nb, 32'h0);
    end
    if (dbg_data_nb !== 32'h0) begin
      fails++; $display("[TB] FAIL nobypass_dbg_old: got %h expected %h", dbg_data_nb, 32'h0);
    end
    @(negedge clk);
    we = 1'b0;
    #1;
    checks += 2;
    if (rd1_nb !== 32'h1234_5678 || dbg_data !== 32'h1234_5678) begin
      fails++; $display("[TB] FAIL bypass_after_edge: got %h/%h expected %h", rd1_nb, dbg_data, 32'h1234_5678);
    end
    if (rd2 !== 32'h1234_5678) begin
      fails++; $display("[TB] FAIL bypass_after_rd2: got %h expected %h", rd2, 32'h1234_5678);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_vs_write;
    reset = 1'b1; we = 1'b1; wa = 5'd29; wd = 32'hAAAA_0000;
    ra1 = 5'd29; ra2 = 5'd8; dbg_addr = 5'd29;
    #1;
    checks += 2;
    if (rd1 !== 32'h0000_3FFC) begin
      fails++; $display("[TB] FAIL reset_no_bypass: got %h expected %h", rd1, 32'h0000_3FFC);
    end
    if (rd2 !== 32'hDEAD_BEEF) begin
      fails++; $display("[TB] FAIL reset_pre_rd2: got %h expected %h", rd2, 32'hDEAD_BEEF);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0; we = 1'b0;
    #1;
    checks += 3;
    if (dbg_data !== 32'h0000_3FFC || rd1 !== 32'h0000_3FFC) begin
      fails++; $display("[TB] FAIL reset_vs_write: got %h/%h expected %h", dbg_data, rd1, 32'h0000_3FFC);
    end
    if (rd2 !== 32'h0) begin
      fails++; $display("[TB] FAIL reset_clears_8: got %h expected %h", rd2, 32'h0);
    end
    if (dbg_data_nb !== 32'h0000_3FFC) begin
      fails++; $display("[TB] FAIL reset_vs_write_nb: got %h expected %h", dbg_data_nb, 32'h0000_3FFC);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] model [32];
    logic [31:0] e1, e2, e1nb, e2nb, ed;
    pulse_reset(1);
    for (int a = 0; a < 32; a++) model[a] = 32'h0;
    model[28] = 32'h0000_1800;
    model[29] = 32'h0000_3FFC;
    for (int n = 0; n < 1000; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra1 = (n % 4 == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = (n % 5 == 0) ? wa : 5'($urandom_range(0, 31));
      dbg_addr = 5'($urandom_range(0, 31));
      e1nb = model[ra1];
      e2nb = model[ra2];
      e1 = (we && wa != 0 && wa == ra1) ? wd : e1nb;
      e2 = (we && wa != 0 && wa == ra2) ? wd : e2nb;
      ed = model[dbg_addr];
      #1;
      checks += 4;
      if (rd1 !== e1 || rd2 !== e2) begin
        fails++; $display("[TB] FAIL rand_rd[%0d]: got %h/%h expected %h/%h", n, rd1, rd2, e1, e2);
      end
      if (rd1_nb !== e1nb || rd2_nb !== e2nb) begin
        fails++; $display("[TB] FAIL rand_rd_nb[%0d]: got %h/%h expected %h/%h", n, rd1_nb, rd2_nb, e1nb, e2nb);
      end
      if (dbg_data !== ed) begin
        fails++; $display("[TB] FAIL rand_dbg[%0d]: got %h expected %h", n, dbg_data, ed);
      end
      if (dbg_data_nb !== ed) begin
        fails++; $display("[TB] FAIL rand_dbg_nb[%0d]: got %h expected %h", n, dbg_data_nb, ed);
      end
      if (we && wa != 0) model[wa] = wd;
      @(negedge clk);
    end
    we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_reset_vs_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
